// File: rtl/add_sub_pipe32_if.sv
// Handshake bus for the two-stage 32-bit adder/subtractor: request side,
// result side and the pipeline flush.
interface add_sub_pipe32_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        c_out;
    logic        ovf;
    logic        zero;

    modport slave (
        input  flush, in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf, zero
    );

    modport master (
        output flush, in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf, zero
    );
endinterface

// File: rtl/add_sub_pipe32.sv
// Two-stage pipelined 32-bit add/subtract: stage 1 resolves the low half with
// carry-lookahead, stage 2 finishes the high half and registers the flags.
module add_sub_pipe32 (
    input logic            clk,
    input logic            rst,
    add_sub_pipe32_if.slave bus
);

    // 16-bit carry-lookahead adder built from four 4-bit groups; returns {cout, sum}.
    function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y,
                                          input logic cin);
        logic [15:0] g;
        logic [15:0] p;
        logic [3:0]  gg;
        logic [3:0]  gp;
        logic [4:0]  gc;
        logic [16:0] c;
        g  = x & y;
        p  = x ^ y;
        gg = '0;
        gp = '0;
        c  = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
        end
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int i = 0; i < 3; i++)
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
        end
        c[16] = gc[4];
        return {c[16], p ^ c[15:0]};
    endfunction

    logic        v1_q, v1_d;
    logic        v2_q, v2_d;
    logic [15:0] lowSum_q, lowSum_d;
    logic        carry16_q, carry16_d;
    logic [15:0] aHi_q, aHi_d;
    logic [15:0] bHi_q, bHi_d;
    logic [31:0] sum_q, sum_d;
    logic        cOut_q, cOut_d;
    logic        ovf_q, ovf_d;
    logic        zero_q, zero_d;

    logic        load1;
    logic        load2;
    logic        inReady;
    logic [31:0] bEff;
    logic [16:0] lowRes;
    logic [16:0] hiRes;

    assign load2   = !v2_q || bus.out_ready;
    assign load1   = !v1_q || load2;
    assign inReady = !v1_q || !v2_q || bus.out_ready;

    // Next-state values for both stages; the high operands carry a[31] and b_eff[31].
    always_comb begin
        bEff      = bus.sub ? ~bus.b : bus.b;
        lowRes    = cla16(bus.a[15:0], bEff[15:0], bus.sub);
        lowSum_d  = lowRes[15:0];
        carry16_d = lowRes[16];
        aHi_d     = bus.a[31:16];
        bHi_d     = bEff[31:16];
        v1_d      = bus.in_valid && inReady;

        hiRes     = {1'b0, aHi_q} + {1'b0, bHi_q} + {16'b0, carry16_q};
        sum_d     = {hiRes[15:0], lowSum_q};
        cOut_d    = hiRes[16];
        ovf_d     = (aHi_q[15] == bHi_q[15]) && (sum_d[31] != aHi_q[15]);
        zero_d    = (sum_d == 32'd0);
        v2_d      = v1_q;
    end

    // Stages load independently; flush only kills the valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            lowSum_q  <= '0;
            carry16_q <= 1'b0;
            aHi_q     <= '0;
            bHi_q     <= '0;
            sum_q     <= '0;
            cOut_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            if (load2) begin
                v2_q   <= v2_d;
                sum_q  <= sum_d;
                cOut_q <= cOut_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
            if (load1) begin
                v1_q      <= v1_d;
                lowSum_q  <= lowSum_d;
                carry16_q <= carry16_d;
                aHi_q     <= aHi_d;
                bHi_q     <= bHi_d;
            end
            if (bus.flush) begin
                v1_q <= 1'b0;
                v2_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = v2_q;
    assign bus.s         = sum_q;
    assign bus.c_out     = cOut_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_add_sub_pipe32.sv
// Directed bench for add_sub_pipe32: reset, arithmetic corners, back-pressure,
// full-rate random stream, flush and mid-stream reset.
module tb_add_sub_pipe32;

    logic clk = 1'b0;
    logic rst;
    int   nCompared = 0;
    int   nMismatch = 0;

    add_sub_pipe32_if bus ();

    add_sub_pipe32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference arithmetic, packed as {s, c_out, ovf, zero}.
    function automatic logic [34:0] refOp(input logic [31:0] x, input logic [31:0] y,
                                          input logic sb);
        logic [31:0] ye;
        logic [32:0] r;
        logic        o;
        ye = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, ye} + {32'b0, sb};
        o  = (x[31] == ye[31]) && (r[31] != x[31]);
        return {r[31:0], r[32], o, (r[31:0] == 32'd0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] av, input logic [31:0] bv,
                                 input logic sv);
        bus.in_valid = v;
        bus.a        = av;
        bus.b        = bv;
        bus.sub      = sv;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatch++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] outWord();
        return 64'({bus.s, bus.c_out, bus.ovf, bus.zero});
    endfunction

    // One isolated operation into an idle pipeline with out_ready high.
    task automatic runOp(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input logic [31:0] es, input logic ec,
                         input logic eo, input logic ez);
        applyStimulus(1'b1, av, bv, sv);
        #1;
        checkOutput({tag, "_inReady"}, 64'(bus.in_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
        checkOutput({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
        tick();
        checkOutput({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        checkOutput({tag, "_result"}, outWord(), 64'({es, ec, eo, ez}));
    endtask

    logic [34:0] bpExp [4];
    logic [31:0] bpA [4];
    logic [31:0] bpB [4];
    logic        bpSub [4];
    logic [31:0] rA [100];
    logic [31:0] rB [100];
    logic        rSub [100];

    initial begin
        int  k;
        int  rcv;
        logic acc;

        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 32'h1234_5678, 32'd1, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("rstValid", 64'(bus.out_valid), 64'd0);
        checkOutput("rstOut", outWord(), 64'd0);
        checkOutput("rstInReady", 64'(bus.in_ready), 64'd1);
        tick();
        tick();
        checkOutput("rstDiscard", 64'(bus.out_valid), 64'd0);

        $display("[TB] basic and overflow vectors");
        runOp("ripple16", 32'h0000_FFFF, 32'd1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        runOp("wrapZero", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        runOp("posOvf",   32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        runOp("negOvf",   32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        runOp("borrow",   32'd5,         32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        runOp("subSelf",  32'h0000_1234, 32'h0000_1234, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();

        $display("[TB] back-pressure");
        bpA[0] = 32'd1;         bpB[0] = 32'd2;    bpSub[0] = 1'b0;
        bpExp[0] = {32'h0000_0003, 1'b0, 1'b0, 1'b0};
        bpA[1] = 32'd10;        bpB[1] = 32'd3;    bpSub[1] = 1'b1;
        bpExp[1] = {32'h0000_0007, 1'b1, 1'b0, 1'b0};
        bpA[2] = 32'hFFFF_FFF0; bpB[2] = 32'h20;   bpSub[2] = 1'b0;
        bpExp[2] = {32'h0000_0010, 1'b1, 1'b0, 1'b0};
        bpA[3] = 32'd0;         bpB[3] = 32'd0;    bpSub[3] = 1'b1;
        bpExp[3] = {32'h0000_0000, 1'b1, 1'b0, 1'b1};
        k   = 0;
        rcv = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.out_ready = (cyc > 4);
            if (k < 4) applyStimulus(1'b1, bpA[k], bpB[k], bpSub[k]);
            else       applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                checkOutput("bpInReady", 64'(bus.in_ready), 64'd0);
                checkOutput("bpHold", outWord(), 64'(bpExp[0]));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (rcv < 4) checkOutput("bpResult", outWord(), 64'(bpExp[rcv]));
                else         checkOutput("bpExtra", 64'(bus.out_valid), 64'd0);
                rcv++;
            end
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) k++;
        end
        checkOutput("bpCount", 64'(rcv), 64'd4);

        $display("[TB] full-throughput random stream");
        for (int i = 0; i < 100; i++) begin
            rA[i]   = $urandom;
            rB[i]   = $urandom;
            rSub[i] = 1'($urandom_range(0, 1));
        end
        rA[10] = 32'h0000_FFFF; rB[10] = 32'h0000_0001; rSub[10] = 1'b0;
        rA[11] = 32'h8000_0000; rB[11] = 32'h8000_0000; rSub[11] = 1'b0;
        rA[12] = 32'h0001_0000; rB[12] = 32'h0000_0001; rSub[12] = 1'b1;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 102; t++) begin
            if (t < 100) applyStimulus(1'b1, rA[t], rB[t], rSub[t]);
            else         applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
            tick();
            checkOutput("thrValid", 64'(bus.out_valid), 64'(t >= 1 && t <= 100));
            if (t >= 1 && t <= 100)
                checkOutput("thrResult", outWord(), 64'(refOp(rA[t-1], rB[t-1], rSub[t-1])));
        end

        $display("[TB] flush");
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 32'd100, 32'd1, 1'b0);
        tick();
        applyStimulus(1'b1, 32'd200, 32'd2, 1'b0);
        tick();
        checkOutput("flPreValid", 64'(bus.out_valid), 64'd1);
        checkOutput("flPreS", 64'(bus.s), 64'd101);
        bus.flush = 1'b1;
        applyStimulus(1'b1, 32'd7, 32'd8, 1'b0);
        #1;
        checkOutput("flInReadyFull", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        #1;
        checkOutput("flInReady", 64'(bus.in_ready), 64'd1);
        tick();
        bus.flush = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
        checkOutput("flValid0", 64'(bus.out_valid), 64'd0);
        tick();
        checkOutput("flValid1", 64'(bus.out_valid), 64'd0);
        tick();
        checkOutput("flValid2", 64'(bus.out_valid), 64'd0);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 32'h10, 32'h20, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h40, 32'h1, 1'b0);
        tick();
        checkOutput("mrPreS", 64'(bus.s), 64'h30);
        rst = 1'b1;
        applyStimulus(1'b1, 32'd9, 32'd9, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("mrValid", 64'(bus.out_valid), 64'd0);
        checkOutput("mrOut", outWord(), 64'd0);
        checkOutput("mrInReady", 64'(bus.in_ready), 64'd1);
        tick();
        checkOutput("mrDiscard", 64'(bus.out_valid), 64'd0);
        runOp("afterRst", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/add_sub_pipe32.md
ADD_SUB_PIPE32 -- requirements
Module: add_sub_pipe32

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  synchronous pipeline kill; drops all in-flight operations.
REQ-005 in_valid  input  1  upstream offers an operation this cycle.
REQ-006 in_ready  output  1  block accepts the offered operation this cycle.
REQ-007 a  input  32  operand A.
REQ-008 b  input  32  operand B.
REQ-009 sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result on s/c_out/ovf/zero is valid.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 s  output  32  sum or difference, modulo 2^32.
REQ-013 c_out  output  1  carry out of bit 31; for subtract, 1 = no borrow.
REQ-014 ovf  output  1  signed two's-complement overflow.
REQ-015 zero  output  1  s == 0.

Function
REQ-016 An operation SHALL be accepted on a cycle with in_valid && in_ready && !flush && !rst.
REQ-017 Operand prep SHALL be: b_eff = sub ? ~b : b; carry-in = sub.
REQ-018 Stage 1 SHALL compute the low-half sum a[15:0] + b_eff[15:0] + sub with 16-bit carry-lookahead (group g/p form) and register it with: the carry into bit 16, a[31:16], b_eff[31:16], a[31], b_eff[31], and valid v1.
REQ-019 Stage 2 SHALL compute the high-half sum from the registered high operands and the registered carry, and SHALL register s, c_out, ovf, zero, and valid v2 (= out_valid).
REQ-020 ovf SHALL be (a[31] == b_eff[31]) && (s[31] != a[31]).
REQ-021 Latency SHALL be exactly 2 cycles from acceptance to out_valid with no stall; throughput SHALL be 1 operation/cycle.
REQ-022 Stage 2 SHALL load when (!v2 || out_ready); on load v2 <= v1.
REQ-023 Stage 1 SHALL load when (!v1 || stage-2 load); on load v1 <= (in_valid && in_ready).
REQ-024 in_ready SHALL equal (!v1 || !v2 || out_ready), combinationally; it SHALL NOT depend on in_valid.
REQ-025 While out_valid && !out_ready, s/c_out/ovf/zero SHALL hold stable and no operation SHALL be lost or duplicated.
REQ-026 Simultaneous acceptance and output consumption SHALL both occur in the same cycle with no bubble.
REQ-027 A registered stage that does not load SHALL hold all of its data registers unchanged.
REQ-028 flush SHALL clear v1 and v2 on the next edge, overriding any acceptance that cycle. Data registers need not be cleared; in_ready is unaffected by flush.
REQ-029 Carry across the half boundary SHALL be exact for all operands, including full-width ripple (e.g. 0x0000FFFF + 1).

Reset
REQ-030 On rst, next edge: v1 = v2 = 0, out_valid = 0, s = 0, c_out = 0, ovf = 0, zero = 0, stage-1 data registers = 0.
REQ-031 rst SHALL take priority over flush and over any handshake; an operation offered during rst SHALL be discarded.
REQ-032 rst asserted mid-operation SHALL discard all in-flight results; the first result after rst deasserts SHALL come from the first operation accepted after deassertion.
REQ-033 After reset, in_ready SHALL be 1 (pipeline empty).

Verification
REQ-034 Basic ops, out_ready = 1:
- a = 0x0000FFFF, b = 1, sub = 0 -> 2 cycles later s = 0x00010000, c_out = 0, ovf = 0, zero = 0.
- a = 0xFFFFFFFF, b = 1, sub = 0 -> s = 0, c_out = 1, zero = 1, ovf = 0.
REQ-035 Signed overflow:
- a = 0x7FFFFFFF, b = 1, sub = 0 -> s = 0x80000000, ovf = 1, c_out = 0.
- a = 0x80000000, b = 1, sub = 1 -> s = 0x7FFFFFFF, ovf = 1, c_out = 1.
- a = 5, b = 7, sub = 1 -> s = 0xFFFFFFFE, c_out = 0, ovf = 0.
REQ-036 Back-pressure: stream 4 back-to-back operations with out_ready held 0 for 3 cycles.
- in_ready deasserts once both stages are full.
- Output holds stable while stalled.
- All 4 results appear in order with none lost or duplicated.
REQ-037 Full throughput: 100 random operations, in_valid = out_ready = 1 -> one result per cycle in order, each matching the reference arithmetic including c_out, ovf, zero.
REQ-038 flush and reset:
- flush asserted with both stages valid -> out_valid = 0 next cycle and those results never appear.
- rst pulsed mid-stream -> all outputs 0, in_ready = 1, and the next accepted operation emerges 2 cycles after acceptance.
